mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter p_data_width, default 8, SHALL set the data width.
REQ-002 Parameter p_address_width, default 20, SHALL set the address width.
REQ-003 i_w_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_w_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_w_req_valid / o_w_req_ready  in/out  1/1  SHALL form the request handshake; transfer occurs when both are 1 at a rising edge.
REQ-006 i_w_req_we  in  1  SHALL select the operation: 1 = write, 0 = read.
REQ-007 i_w_req_addr  in  p_address_width  SHALL carry the request address; i_w_req_wdata  in  p_data_width  SHALL carry the write data.
REQ-008 o_w_rsp_valid / i_w_rsp_ready  out/in  1/1  SHALL form the read-response handshake; o_w_rsp_rdata  out  p_data_width  SHALL carry the read data.
REQ-009 o_w_wr_done  out  1  SHALL pulse for one cycle per completed write.
REQ-010 o_w_mem_address  out  p_address_width, o_w_mem_din  out  p_data_width, o_w_mem_we  out  1, o_w_mem_oe  out  1  SHALL drive the single-port memory.
REQ-011 i_w_mem_dout  in  p_data_width  SHALL receive the memory read data.

Function
REQ-012 The FSM SHALL have states IDLE, WRITE, READ, RESP and TURN.
REQ-013 o_w_req_ready SHALL be 1 only in IDLE.
REQ-014 On acceptance with i_w_req_we=1, the block SHALL register address and wdata and go to WRITE.
REQ-015 On acceptance with i_w_req_we=0, the block SHALL register address and go to READ.
REQ-016 WRITE SHALL last exactly one cycle with we=1, oe=0 and address/din stable; it SHALL then pulse o_w_wr_done and return to IDLE.
REQ-017 READ SHALL last exactly one cycle with oe=1 and we=0.
REQ-018 At the rising edge that ends READ, i_w_mem_dout SHALL be captured into o_w_rsp_rdata and the FSM SHALL enter RESP.
REQ-019 In RESP, o_w_rsp_valid SHALL be 1 and o_w_rsp_rdata SHALL remain stable until i_w_rsp_ready=1 at an edge, after which the FSM SHALL go to IDLE.
REQ-020 Read latency SHALL be 2 edges from acceptance to first rsp_valid; write latency SHALL be 2 edges from acceptance to wr_done.
REQ-021 o_w_mem_we and o_w_mem_oe SHALL never both be 1 in any cycle.
REQ-022 In IDLE, RESP and TURN, both we and oe SHALL be 0.
REQ-023 Requests SHALL be ignored while o_w_req_ready=0, with no buffering.
REQ-024 Both address extremes (0 and all-ones) SHALL be supported; there is no wrap-around or address arithmetic.
REQ-025 A last_was_read flag SHALL be set by READ and cleared by WRITE.

Reset
REQ-026 While i_w_rst_n=0, all outputs SHALL be forced immediately to 0 regardless of clock: state=IDLE, we=oe=0, address/din/rdata=0, rsp_valid=0, wr_done=0, last_was_read=0.
REQ-027 o_w_req_ready SHALL read 1 only after reset is released.
REQ-028 A reset asserted during WRITE SHALL deassert we before the next edge, so the memory is not written.
REQ-029 A reset asserted during RESP SHALL discard the pending response.

Configuration
REQ-030 With macro MEM_CTRL_TURNAROUND_EN defined, a write accepted while last_was_read=1 SHALL pass through TURN (one cycle, we=oe=0) before WRITE, giving write latency 3; the first write is unaffected.
REQ-031 Without MEM_CTRL_TURNAROUND_EN, TURN SHALL be unreachable and write latency SHALL always be 2.

Structure
REQ-032 Package mem_ctrl_pkg SHALL hold the state enumeration and the operation-encoding constants (OP_READ=0, OP_WRITE=1).
REQ-033 The RTL SHALL be one module with no sub-module.
REQ-034 The bench SHALL instantiate the team's single-port memory model (same parameters) as the downstream device.

Verification
REQ-035 Reset, then write addr=0x00005 data=0xA5 -> one WRITE cycle (we=1, oe=0), then wr_done pulse; a read of 0x00005 returns 0xA5 with rsp_valid 2 edges after acceptance.
REQ-036 Read with rsp_ready held 0 for 4 cycles -> rsp_valid=1 and rdata stable for all 4 cycles; req_ready=0 throughout; release rsp_ready -> IDLE next edge.
REQ-037 Write 0xFFFFF=0x3C, write 0x00000=0xC3, read both -> 0x3C and 0xC3 respectively.
REQ-038 Assert i_w_rst_n=0 mid-WRITE (addr 0x10, data 0x77) -> we falls without an edge; a subsequent read of 0x10 returns the prior value.
REQ-039 With MEM_CTRL_TURNAROUND_EN: read then write back-to-back -> one TURN cycle with we=oe=0 and write latency 3; without the macro -> latency 2.
REQ-040 A 1000-operation random back-to-back sequence -> never we=oe=1 together, and all reads match a scoreboard.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM state encoding and request operation codes for mem_ctrl.
package mem_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, TURN} state_t;
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port memory controller with valid/ready request and read-response handshakes.
// Define MEM_CTRL_TURNAROUND_EN to insert one idle TURN cycle on a write that follows a read.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int p_data_width    = 8,
   parameter int p_address_width = 20
) (
   input  logic                       i_w_clk,
   input  logic                       i_w_rst_n,
   input  logic                       i_w_req_valid,
   output logic                       o_w_req_ready,
   input  logic                       i_w_req_we,
   input  logic [p_address_width-1:0] i_w_req_addr,
   input  logic [p_data_width-1:0]    i_w_req_wdata,
   output logic                       o_w_rsp_valid,
   input  logic                       i_w_rsp_ready,
   output logic [p_data_width-1:0]    o_w_rsp_rdata,
   output logic                       o_w_wr_done,
   output logic [p_address_width-1:0] o_w_mem_address,
   output logic [p_data_width-1:0]    o_w_mem_din,
   output logic                       o_w_mem_we,
   output logic                       o_w_mem_oe,
   input  logic [p_data_width-1:0]    i_w_mem_dout
);
`ifdef MEM_CTRL_TURNAROUND_EN
   localparam bit TURN_EN = 1'b1;
`else
   localparam bit TURN_EN = 1'b0;
`endif
   state_t                     state_q, state_d;
   logic [p_address_width-1:0] addr_q, addr_d;
   logic [p_data_width-1:0]    din_q, din_d;
   logic [p_data_width-1:0]    rdata_q, rdata_d;
   logic                       done_q, done_d;
   logic                       last_rd_q, last_rd_d;

   always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         din_q     <= '0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         last_rd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         last_rd_q <= last_rd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      din_d     = din_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      last_rd_d = last_rd_q;
      case (state_q)
         IDLE:
            if (i_w_req_valid) begin
               addr_d = i_w_req_addr;
               if (i_w_req_we == OP_WRITE) begin
                  din_d   = i_w_req_wdata;
                  state_d = (TURN_EN && last_rd_q) ? TURN : WRITE;
               end else begin
                  state_d = READ;
               end
            end
         TURN:  state_d = WRITE;
         WRITE: begin
            done_d    = 1'b1;
            last_rd_d = 1'b0;
            state_d   = IDLE;
         end
         READ: begin
            rdata_d   = i_w_mem_dout;
            last_rd_d = 1'b1;
            state_d   = RESP;
         end
         RESP:    state_d = i_w_rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   // ready is gated by reset so it never reads 1 while reset is held
   assign o_w_req_ready   = (state_q == IDLE) && i_w_rst_n;
   assign o_w_rsp_valid   = (state_q == RESP);
   assign o_w_rsp_rdata   = rdata_q;
   assign o_w_wr_done     = done_q;
   assign o_w_mem_address = addr_q;
   assign o_w_mem_din     = din_q;
   assign o_w_mem_we      = (state_q == WRITE);
   assign o_w_mem_oe      = (state_q == READ);
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random checks of mem_ctrl against a behavioural single-port memory.
module tb_mem_ctrl;
   localparam int DW = 8;
   localparam int AW = 20;
`ifdef MEM_CTRL_TURNAROUND_EN
   localparam bit TE = 1'b1;
`else
   localparam bit TE = 1'b0;
`endif
   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we, rsp_valid, rsp_ready, wr_done;
   logic [AW-1:0] req_addr, mem_addr;
   logic [DW-1:0] req_wdata, rsp_rdata, mem_din, mem_dout;
   logic          mem_we, mem_oe;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_mem [0:(1<<AW)-1];
   int            total = 0;
   int            bad = 0;
   bit            last_rd = 1'b0;

   always #5 clk = ~clk;

   mem_ctrl #(.p_data_width(DW), .p_address_width(AW)) dut (
      .i_w_clk(clk), .i_w_rst_n(rst_n),
      .i_w_req_valid(req_valid), .o_w_req_ready(req_ready),
      .i_w_req_we(req_we), .i_w_req_addr(req_addr), .i_w_req_wdata(req_wdata),
      .o_w_rsp_valid(rsp_valid), .i_w_rsp_ready(rsp_ready), .o_w_rsp_rdata(rsp_rdata),
      .o_w_wr_done(wr_done),
      .o_w_mem_address(mem_addr), .o_w_mem_din(mem_din),
      .o_w_mem_we(mem_we), .o_w_mem_oe(mem_oe), .i_w_mem_dout(mem_dout)
   );

   // asynchronous-read, synchronous-write single-port memory
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
   assign mem_dout = mem_oe ? mem[mem_addr] : '0;

   always @(negedge clk) if (rst_n === 1'b1) begin
      total++;
      assert (!(mem_we && mem_oe)) else begin
         bad++;
         $error("FAIL we_oe_excl got we=%b oe=%b exp not both 1", mem_we, mem_oe);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      if (TE && last_rd) begin
         chk("turn_we", 32'(mem_we), 0);
         chk("turn_oe", 32'(mem_oe), 0);
         chk("turn_ready", 32'(req_ready), 0);
         @(negedge clk);
      end
      chk("wr_we", 32'(mem_we), 1);
      chk("wr_oe", 32'(mem_oe), 0);
      chk("wr_addr", 32'(mem_addr), 32'(a));
      chk("wr_din", 32'(mem_din), 32'(d));
      chk("wr_done_early", 32'(wr_done), 0);
      @(negedge clk);
      chk("wr_done", 32'(wr_done), 1);
      chk("wr_ready", 32'(req_ready), 1);
      chk("wr_we_off", 32'(mem_we), 0);
      exp_mem[a] = d;
      last_rd = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = (hold == 0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_oe", 32'(mem_oe), 1);
      chk("rd_we", 32'(mem_we), 0);
      chk("rd_addr", 32'(mem_addr), 32'(a));
      chk("rd_valid_early", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_mem[a]));
      chk("rsp_memoff", 32'(mem_oe | mem_we), 0);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 1);
         chk("hold_rdata", 32'(rsp_rdata), 32'(exp_mem[a]));
         chk("hold_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_done", 32'(rsp_valid), 0);
      chk("rd_ready", 32'(req_ready), 1);
      last_rd = 1'b1;
   endtask

   initial begin
      logic [AW-1:0] addrs [6];
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = '0;
         exp_mem[i] = '0;
      end
      #3;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_we_oe", {30'd0, mem_we, mem_oe}, 0);
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_done", 32'(wr_done), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_rdata", 32'(rsp_rdata), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_rst_ready", 32'(req_ready), 1);
      @(negedge clk);
      do_write(20'h00005, 8'hA5);
      do_read(20'h00005, 0);
      do_read(20'h00005, 4);
      do_write(20'hFFFFF, 8'h3C);
      do_write(20'h00000, 8'hC3);
      do_read(20'hFFFFF, 0);
      do_read(20'h00000, 0);
      do_write(20'h00010, 8'h11);
      // reset in the middle of the WRITE cycle must cancel the memory write
      req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00010; req_wdata = 8'h77;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_we", 32'(mem_we), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_we", 32'(mem_we), 0);
      chk("mid_rst_addr", 32'(mem_addr), 0);
      chk("mid_rst_din", 32'(mem_din), 0);
      @(negedge clk);
      chk("mid_rst_done", 32'(wr_done), 0);
      rst_n = 1'b1;
      last_rd = 1'b0;
      do_read(20'h00010, 0);
      // reset during RESP drops the pending response
      req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00005; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("resp_pend", 32'(rsp_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("resp_rst_valid", 32'(rsp_valid), 0);
      chk("resp_rst_rdata", 32'(rsp_rdata), 0);
      @(negedge clk);
      rst_n = 1'b1; rsp_ready = 1'b1; last_rd = 1'b0;
      #1 chk("resp_rst_ready", 32'(req_ready), 1);
      @(negedge clk);
      do_read(20'h00005, 0);
      do_write(20'h00020, 8'h5A);
      addrs = '{20'h00000, 20'hFFFFF, 20'h00005, 20'h00010, 20'h00020, 20'h7FFFF};
      for (int n = 0; n < 1000; n++) begin
         logic [AW-1:0] a;
         a = addrs[$urandom_range(5)];
         if ($urandom_range(1) == 1) do_write(a, DW'($urandom));
         else do_read(a, int'($urandom_range(2)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
